// File: rtl/img_readout_packer.sv
// img_readout_packer: buffers one fixed-length image readout into an output FIFO with a last-word flag.
// Define IMG_READOUT_PACKER_CHECKSUM_EN to append Fletcher-32 words (B, then A) after the pixels.
module img_readout_packer #(
   parameter int WordCount = 8 + 4096*4096,
   parameter int FifoDepth = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        readout_rst,
   input  logic        readout_start,
   input  logic        readout_ready,
   output logic        readout_trigger,
   input  logic [15:0] readout_data,
   output logic        out_ready,
   input  logic        out_trigger,
   output logic [15:0] out_data,
   output logic        out_last,
   output logic        busy
);
   localparam int CntW = $clog2(WordCount + 1);
   localparam int AddrW = $clog2(FifoDepth);
   typedef enum logic [2:0] {IDLE, STREAM, SUM0, SUM1, DRAIN} state_t;
   state_t state_q, state_d;
   logic [CntW-1:0] wcnt_q, wcnt_d, wcnt_inc;
   logic start_q, start_edge, accept, last_word;
   logic [16:0] mem [FifoDepth];
   logic [AddrW-1:0] wp_q, rp_q;
   logic [AddrW:0] fcnt_q, fcnt_d;
   logic full, wr, rd, flush, wlast;
   logic [15:0] wdata;
`ifdef IMG_READOUT_PACKER_CHECKSUM_EN
   logic [15:0] a_q, a_d, b_q, b_d, a_new, b_new;
   logic [16:0] a_sum, b_sum;
   assign a_sum = {1'b0, a_q} + {1'b0, readout_data};
   assign a_new = a_sum >= 17'd65535 ? 16'(a_sum - 17'd65535) : a_sum[15:0];
   assign b_sum = {1'b0, b_q} + {1'b0, a_new};
   assign b_new = b_sum >= 17'd65535 ? 16'(b_sum - 17'd65535) : b_sum[15:0];
`endif
   assign full = fcnt_q == (AddrW+1)'(FifoDepth);
   assign readout_trigger = state_q == STREAM && !full;
   assign accept = readout_ready && readout_trigger;
   assign out_ready = fcnt_q != '0;
   assign rd = out_ready && out_trigger;
   assign out_data = out_ready ? mem[rp_q][15:0] : 16'h0000;
   assign out_last = out_ready && mem[rp_q][16];
   assign busy = state_q != IDLE;
   assign start_edge = readout_start ^ start_q;
   assign wcnt_inc = wcnt_q + 1'b1;
   assign last_word = wcnt_inc == CntW'(WordCount);
   assign fcnt_d = fcnt_q + (AddrW+1)'(wr) - (AddrW+1)'(rd);
   always_comb begin
      state_d = state_q;
      wcnt_d = wcnt_q;
      wr = 1'b0;
      wdata = readout_data;
      wlast = 1'b0;
      flush = 1'b0;
`ifdef IMG_READOUT_PACKER_CHECKSUM_EN
      a_d = a_q;
      b_d = b_q;
`endif
      if (readout_rst) begin
         state_d = IDLE;
         wcnt_d = '0;
         flush = 1'b1;
`ifdef IMG_READOUT_PACKER_CHECKSUM_EN
         a_d = '0;
         b_d = '0;
`endif
      end else begin
         if (accept) begin
            wr = 1'b1;
            wcnt_d = wcnt_inc;
`ifdef IMG_READOUT_PACKER_CHECKSUM_EN
            a_d = a_new;
            b_d = b_new;
            state_d = last_word ? SUM0 : STREAM;
`else
            wlast = last_word;
            state_d = last_word ? DRAIN : STREAM;
`endif
         end
`ifdef IMG_READOUT_PACKER_CHECKSUM_EN
         if (state_q == SUM0 && !full) begin
            wr = 1'b1;
            wdata = b_q;
            state_d = SUM1;
         end
         if (state_q == SUM1 && !full) begin
            wr = 1'b1;
            wdata = a_q;
            wlast = 1'b1;
            state_d = DRAIN;
         end
`endif
         if (state_q == DRAIN && !out_ready) state_d = IDLE;
         // a new readout restarts counting but keeps whatever is still buffered
         if (start_edge) begin
            state_d = STREAM;
            wcnt_d = '0;
`ifdef IMG_READOUT_PACKER_CHECKSUM_EN
            a_d = '0;
            b_d = '0;
`endif
         end
      end
   end
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         wcnt_q <= '0;
         start_q <= 1'b0;
         wp_q <= '0;
         rp_q <= '0;
         fcnt_q <= '0;
`ifdef IMG_READOUT_PACKER_CHECKSUM_EN
         a_q <= '0;
         b_q <= '0;
`endif
      end else begin
         state_q <= state_d;
         wcnt_q <= wcnt_d;
         start_q <= readout_start;
`ifdef IMG_READOUT_PACKER_CHECKSUM_EN
         a_q <= a_d;
         b_q <= b_d;
`endif
         if (flush) begin
            wp_q <= '0;
            rp_q <= '0;
            fcnt_q <= '0;
         end else begin
            if (wr) wp_q <= wp_q + 1'b1;
            if (rd) rp_q <= rp_q + 1'b1;
            fcnt_q <= fcnt_d;
         end
      end
   end
   always_ff @(posedge clk) begin
      if (wr) mem[wp_q] <= {wlast, wdata};
   end
endmodule

// File: doc/img_readout_packer.md
IMG_READOUT_PACKER -- requirements
Module: img_readout_packer

Interface
REQ-001 The block SHALL have parameter WordCount, default 8+4096*4096, giving the number of words per readout (header plus pixels).
REQ-002 The block SHALL have parameter FifoDepth, default 4, giving the number of entries in the output buffer (power of two, minimum 2).
REQ-003 Port clk  input  1  sole clock; every port below is in this domain.
REQ-004 Port rst  input  1  reset, asynchronous and active-high.
REQ-005 Port readout_rst  input  1  synchronous single-cycle clear pulse from the image controller.
REQ-006 Port readout_start  input  1  toggle; each edge begins one readout.
REQ-007 Port readout_ready  input  1  readout_data is valid.
REQ-008 Port readout_trigger  output  1  block accepts readout_data this cycle.
REQ-009 Port readout_data  input  16  upstream word.
REQ-010 Port out_ready  output  1  out_data is valid.
REQ-011 Port out_trigger  input  1  consumer takes out_data this cycle.
REQ-012 Port out_data  output  16  packed output word.
REQ-013 Port out_last  output  1  qualifies out_data as the final word of the readout.
REQ-014 Port busy  output  1  high in every state except Idle.

Function
REQ-015 Upstream transfer SHALL occur when readout_ready && readout_trigger; downstream transfer SHALL occur when out_ready && out_trigger.
REQ-016 The state machine SHALL have states Idle, Stream, Sum0, Sum1 and Drain.
REQ-017 An edge on readout_start (compared against a registered copy) SHALL, from any state, clear the word counter and checksum and enter Stream on the next cycle; the FIFO SHALL NOT be cleared.
REQ-018 readout_trigger SHALL equal (state==Stream && FIFO not full), with no combinational path from out_trigger.
REQ-019 Every accepted word SHALL be written to the FIFO and counted; the counter SHALL be `RegWidth(WordCount) bits wide.
REQ-020 Acceptance of word number WordCount SHALL move Stream to Sum0 on the next cycle, and readout_trigger SHALL be low from that cycle onward.
REQ-021 The Fletcher-32 checksum SHALL be computed per accepted word w as A=(A+w) mod 65535 then B=(B+A_new) mod 65535, each using a 17-bit sum followed by one conditional subtraction of 65535; both A and B SHALL start at 0.
REQ-022 Sum0 SHALL write B to the FIFO when it is not full and then go to Sum1; Sum1 SHALL write A when the FIFO is not full and then go to Drain.
REQ-023 Drain SHALL return to Idle once the FIFO is empty.
REQ-024 out_last SHALL be high exactly when out_data is the A word.
REQ-025 FIFO write to read latency SHALL be 1 cycle; a simultaneous read and write when full SHALL be permitted; no word SHALL be dropped or duplicated under any out_trigger pattern.
REQ-026 readout_rst SHALL flush the FIFO, clear the counter and checksum, and force Idle; if it coincides with a readout_start edge, readout_rst SHALL win and the edge SHALL be discarded.
REQ-027 Words presented while in Idle SHALL NOT be accepted.

Reset
REQ-028 While rst is high, all state SHALL be cleared asynchronously: Idle, FIFO empty, counter=0, A=B=0, registered readout_start copy=0.
REQ-029 While rst is high, readout_trigger, out_ready, out_last and busy SHALL be 0 and out_data SHALL be 0x0000.
REQ-030 After rst is released, the first readout_start edge relative to 0 SHALL begin a readout.

Configuration
REQ-031 With IMG_READOUT_PACKER_CHECKSUM_EN defined, the checksum logic and states Sum0/Sum1 SHALL be built as described above.
REQ-032 With IMG_READOUT_PACKER_CHECKSUM_EN undefined, Stream SHALL go directly to Drain, no checksum words SHALL be emitted, and out_last SHALL qualify data word number WordCount.

Verification
REQ-033 Scenario (WordCount=4, CHECKSUM_EN): words 0x0001, 0x0002, 0x0003, 0x0004 -> out 0x0001, 0x0002, 0x0003, 0x0004, 0x0014, 0x000A, with out_last only on 0x000A.
REQ-034 Scenario (WordCount=2): 0xFFFE, 0x0003 -> checksum words 0x0001 then 0x0002 (modulo wrap).
REQ-035 Scenario: out_trigger held low while streaming -> readout_trigger falls after 4 words are accepted; releasing out_trigger produces all words in order with no loss.
REQ-036 Scenario: readout_rst asserted mid-Stream after 2 words -> next cycle Idle, out_ready=0, busy=0; a following readout_start edge yields a complete fresh readout.
REQ-037 Scenario: rst asserted in Sum1 -> all outputs 0 immediately, without waiting for a clk edge.
REQ-038 Scenario (CHECKSUM_EN undefined, WordCount=4): 4 words -> exactly 4 output words, out_last on the 4th.
